div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU.
- Sits in EX, in parallel with the multiplier, and is the producer side of the HI/LO register.
- On completion it presents {remainder, quotient}; the pipeline forwards these as the HI/LO write data (HI = remainder, LO = quotient) with the HI/LO write enable.
- Stalls the pipeline via ready_o handshake; can be annulled by exception/flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; level-held by EX until ready_o seen.
- annul_i  in  1  abort current/pending division.
- result_o  out  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}; valid while ready_o=1.
- ready_o  out  1  result valid.

Behaviour:
- Reset (async, rst low): state=FREE, cnt=0, result_o=0, ready_o=0; takes effect immediately, including mid-operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i!=0: latch operands; if signed_div_i and negative, latch two's-complement magnitude; record quotient sign (sign1^sign2) and remainder sign (sign1); partial remainder=0, cnt=0; ->ON.
  - start_i=1, annul_i=0, opdata2_i==0: ->BYZERO (with DIV_ZERO_FASTPATH_EN) or ->ON with zero flag set (without).
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- ON: one iteration per edge.
  - Shift {rem, dividend} left 1; if rem >= divisor, subtract and shift in quotient bit 1, else 0; cnt++.
  - annul_i=1 in any ON cycle: ->FREE next edge; ready_o stays 0; result_o=0.
  - After DATA_W iterations (cnt==DATA_W-1 at edge): apply signs (negate quotient if quotient-sign, negate remainder if remainder-sign); ->END; result_o loaded; ready_o<=1.
- Latency: counting the start-accepting edge as edge 1, ready_o rises after edge DATA_W+1 (33 for DATA_W=32).
- BYZERO: next edge ->END, result loaded, ready_o<=1 (ready after edge 2).
- END:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0: ->FREE; ready_o<=0, result_o<=0.
  - annul_i=1 in END: ->FREE, outputs cleared.
- start_i changes or operand changes while ON/END are ignored; operands are latched only in FREE.
- Divide by zero (either mode): result = {opdata1_i as latched raw value, all-ones}, i.e. HI=dividend, LO=0xFFFFFFFF. No trap; software checks.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (natural wrap, no flag).
- Arithmetic: partial remainder compare/subtract is DATA_W+1 bits wide to hold the carry.

Optional Feature:
- Macro: DIV_ZERO_FASTPATH_EN.
- Defined: zero divisor detected in FREE, goes through BYZERO, ready after edge 2.
- Undefined: BYZERO state absent. Zero divisor runs the full DATA_W iterations in ON with a latched zero flag, then loads the same defined result at END; ready after edge 33.
- Result values are identical either way; only latency differs.

Test Plan:
- DIVU 100/7 -> after edge 33, ready_o=1, result_o={0x00000002, 0x0000000E}; drop start_i -> next edge ready_o=0, result_o=0.
- DIV -7 (0xFFFFFFF9) / 2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Same operands as DIVU -> {0x80000000, 0x00000000}.
- Divisor 0, dividend 0x12345678 -> result_o={0x12345678, 0xFFFFFFFF}; ready after edge 2 with DIV_ZERO_FASTPATH_EN, after edge 33 without.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises. New DIVU 9/3 accepted on the following cycle -> {0, 3} at edge 33 of that op.
- rst driven low mid-ON (iteration 20) -> ready_o=0, result_o=0 immediately without a clock edge. After release, state is FREE and a new start divides correctly.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (HI/LO producer)
//
// Optional feature macro: DIV_ZERO_FASTPATH_EN
//   defined   : a zero divisor is caught in FREE and finishes through BYZERO (ready after edge 2)
//   undefined : a zero divisor runs all DATA_W iterations and the zero result is substituted at the end
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held by EX until ready_o is seen
//   annul_i      abort the current/pending division
//   result_o     {remainder, quotient}, valid while ready_o = 1
//   ready_o      result valid
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

`ifdef DIV_ZERO_FASTPATH_EN
    typedef enum logic [1:0] {FREE, ON, END, BYZERO} state_t;
`else
    typedef enum logic [1:0] {FREE, ON, END} state_t;
`endif

    state_t state, state_n;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rem;      // partial remainder
    logic [DATA_W-1:0] dvd;      // dividend magnitude, shifts out as quotient bits shift in
    logic [DATA_W-1:0] dvs;      // divisor magnitude
    logic [DATA_W-1:0] raw;      // dividend exactly as presented, for the divide-by-zero result
    logic              qneg;
    logic              rneg;
    logic              zero;

    logic              neg1;
    logic              neg2;
    logic              accept;

    logic [DATA_W:0]   rem_sh;
    logic              ge;
    logic [DATA_W-1:0] rem_sub;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] dvd_nx;
    logic [DATA_W-1:0] q_fin;
    logic [DATA_W-1:0] r_fin;

    assign neg1   = signed_div_i & opdata1_i[DATA_W-1];
    assign neg2   = signed_div_i & opdata2_i[DATA_W-1];
    assign accept = start_i & ~annul_i;

    // One restoring step. The shifted remainder needs DATA_W+1 bits for the
    // compare; when the subtract is taken the difference is below the divisor,
    // so the low DATA_W bits of the subtraction are exact.
    always_comb begin
        rem_sh  = {rem, dvd[DATA_W-1]};
        ge      = rem_sh >= {1'b0, dvs};
        rem_sub = rem_sh[DATA_W-1:0] - dvs;
        rem_nx  = ge ? rem_sub : rem_sh[DATA_W-1:0];
        dvd_nx  = {dvd[DATA_W-2:0], ge};
        q_fin   = qneg ? (~dvd_nx + 1'b1) : dvd_nx;
        r_fin   = rneg ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FREE: begin
                if (accept) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    state_n = (opdata2_i == '0) ? BYZERO : ON;
`else
                    state_n = ON;
`endif
                end
            end
`ifdef DIV_ZERO_FASTPATH_EN
            BYZERO: state_n = annul_i ? FREE : END;
`endif
            ON: begin
                if (annul_i) begin
                    state_n = FREE;
                end else if (cnt == LAST) begin
                    state_n = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_n = FREE;
                end
            end
            default: state_n = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            raw      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            zero     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        raw  <= opdata1_i;
                        dvd  <= neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
                        dvs  <= neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
                        qneg <= neg1 ^ neg2;
                        rneg <= neg1;
                        zero <= (opdata2_i == '0);
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
`ifdef DIV_ZERO_FASTPATH_EN
                BYZERO: begin
                    if (!annul_i) begin
                        result_o <= {raw, {DATA_W{1'b1}}};
                        ready_o  <= 1'b1;
                    end
                end
`endif
                ON: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            // A zero divisor iterates to no purpose; its defined result replaces it.
                            result_o <= zero ? {raw, {DATA_W{1'b1}}} : {r_fin, q_fin};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain integer arithmetic (truncating division).
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: an accepted request becomes ready a fixed
    // number of edges later unless annulled; ready drops once start is released.
    logic        m_act, m_rdy;
    int          m_left;
    logic [63:0] m_exp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act  <= 1'b0;
            m_rdy  <= 1'b0;
            m_left <= 0;
            m_exp  <= 64'd0;
        end else if (m_rdy) begin
            if (!start_i || annul_i) m_rdy <= 1'b0;
        end else if (m_act) begin
            if (annul_i) begin
                m_act <= 1'b0;
            end else if (m_left == 1) begin
                m_act <= 1'b0;
                m_rdy <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start_i && !annul_i) begin
            m_act  <= 1'b1;
            m_left <= (opdata2_i == 32'd0) ? ZLAT - 1 : 32;
            m_exp  <= model(opdata1_i, opdata2_i, signed_div_i);
        end
    end

    always @(negedge clk) begin
        logic [63:0] want;
        want = m_rdy ? m_exp : 64'd0;
        n_chk++;
        if (ready_o !== m_rdy || result_o !== want) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t ready_o=%b result_o=%h required ready=%b result=%h",
                     $time, ready_o, result_o, m_rdy, want);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ready_o && n < 45);
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input int lat);
        int n;
        start_op(a, b, s);
        wait_ready(n);
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_result"}, result_o, exp);
        @(posedge clk);
        #1;
        check({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        opdata1_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check({name, "_release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run("divu_100_7",    32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}, 33);
        run("div_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run("div_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run("div_ovf",       32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}, 33);
        run("divu_ovf_ops",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0000_0000}, 33);
        run("div_zero",      32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT);
        run("divu_zero",     32'h1234_5678,  32'd0,          1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT);
        run("div_m100_m7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33);
        run("divu_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33);

        // Annul at iteration 10, then a fresh request.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) break;
        end
        check("annul_no_ready", {63'd0, ready_o}, 64'd0);
        run("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

        // Asynchronous reset mid-iteration.
        start_op(32'd1000, 32'd10, 1'b0);
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_on", {63'd0, ready_o} | result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run("after_rst", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 33);

        // Asynchronous reset while a result is being held.
        start_op(32'd50, 32'd6, 1'b0);
        wait_ready(n);
        check("pre_rst_ready", {63'd0, ready_o}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_end", {63'd0, ready_o} | result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run("after_rst2", 32'd50, 32'd6, 1'b0, {32'd2, 32'd8}, 33);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
